// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: register address type,
// decoded request and registered operand bundles, and an address-match helper.
package operand_fetch_pkg;

  localparam int OF_WIDTH     = 32;
  localparam int OF_DEPTH_REG = 8;
  localparam int OF_ADDR_W    = 3;

  typedef logic [OF_ADDR_W-1:0] regAddr;

  typedef struct packed {
    regAddr rs;
    regAddr rt;
    regAddr rd;
    logic   wr_en;
  } operand_req_t;

  typedef struct packed {
    logic [OF_WIDTH-1:0] op_a;
    logic [OF_WIDTH-1:0] op_b;
    regAddr              rd;
    logic                wr_en;
  } operand_out_t;

  // True when a qualified write-back targets the given register.
  function automatic logic addr_hit(input logic en, input regAddr a, input regAddr b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer is accepted, cleared by its write-back or by flushing the held writer.
// Answers the RAW/WAW hazard question for the incoming rs/rt/rd.
// Build option: OPERAND_BYPASS_EN (defined = a same-cycle write-back to a
// source register resolves its RAW hazard; undefined = it still stalls).
module reg_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int DEPTH_REG = OF_DEPTH_REG
) (
  input  logic         clk,
  input  logic         rst,
  input  operand_req_t req_i,
  input  logic         wb_valid_i,
  input  regAddr       wb_addr_i,
  input  logic         set_en_i,
  input  regAddr       set_addr_i,
  input  logic         clr_en_i,
  input  regAddr       clr_addr_i,
  output logic         hazard_o
);

  logic [DEPTH_REG-1:0] pending_q;
  logic [DEPTH_REG-1:0] pending_d;
  logic                 hazRs;
  logic                 hazRt;
  logic                 hazRd;

  // Next pending state: clears first, then the new writer's set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i && (wb_addr_i != '0)) begin
      pending_d[wb_addr_i] = 1'b0;
    end
    if (clr_en_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      pending_d[set_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Hazard query for both sources and the destination of the incoming request.
  always_comb begin
`ifdef OPERAND_BYPASS_EN
    hazRs = (req_i.rs != '0) && pending_q[req_i.rs] &&
            !addr_hit(wb_valid_i, wb_addr_i, req_i.rs);
    hazRt = (req_i.rt != '0) && pending_q[req_i.rt] &&
            !addr_hit(wb_valid_i, wb_addr_i, req_i.rt);
`else
    hazRs = (req_i.rs != '0) &&
            (pending_q[req_i.rs] || addr_hit(wb_valid_i, wb_addr_i, req_i.rs));
    hazRt = (req_i.rt != '0) &&
            (pending_q[req_i.rt] || addr_hit(wb_valid_i, wb_addr_i, req_i.rt));
`endif
    hazRd = req_i.wr_en && (req_i.rd != '0) && pending_q[req_i.rd] &&
            !addr_hit(wb_valid_i, wb_addr_i, req_i.rd);
    hazard_o = hazRs || hazRt || hazRd;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file for a decoded instruction,
// optionally bypasses the same-cycle write-back, stalls on pending-write
// hazards, and hands registered operands to execute over valid/ready.
// Build option: OPERAND_BYPASS_EN enables the write-back bypass muxes.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH     = OF_WIDTH,
  parameter int DEPTH_REG = OF_DEPTH_REG,
  parameter int ADDR_W    = OF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr_en,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [WIDTH-1:0]  rf_rd_data1,
  input  logic [WIDTH-1:0]  rf_rd_data2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_op_a,
  output logic [WIDTH-1:0]  out_op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_en
);

  operand_req_t       req;
  operand_out_t       out_q;
  operand_out_t       out_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic               hazard;
  logic               accept;
  logic               sbSet;
  logic               sbClr;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;

  assign req         = '{rs: in_rs, rt: in_rt, rd: in_rd, wr_en: in_wr_en};
  assign rf_rd_addr1 = in_rs;
  assign rf_rd_addr2 = in_rt;

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // A new writer marks its destination; flushing a held writer releases it.
  assign sbSet = accept && in_wr_en && (in_rd != '0);
  assign sbClr = flush && out_valid_q && out_q.wr_en;

  reg_scoreboard #(
    .DEPTH_REG (DEPTH_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .set_en_i   (sbSet),
    .set_addr_i (in_rd),
    .clr_en_i   (sbClr),
    .clr_addr_i (out_q.rd),
    .hazard_o   (hazard)
  );

  // Operand selection: reg0 reads zero, otherwise register file or bypass.
  always_comb begin
    opA = '0;
    opB = '0;
`ifdef OPERAND_BYPASS_EN
    if (in_rs != '0) begin
      opA = addr_hit(wb_valid, wb_addr, in_rs) ? wb_data : rf_rd_data1;
    end
    if (in_rt != '0) begin
      opB = addr_hit(wb_valid, wb_addr, in_rt) ? wb_data : rf_rd_data2;
    end
`else
    if (in_rs != '0) begin
      opA = rf_rd_data1;
    end
    if (in_rt != '0) begin
      opB = rf_rd_data2;
    end
`endif
  end

`ifndef OPERAND_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  // Output register next state: flush drops, accept loads, consume empties.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d.op_a  = opA;
      out_d.op_b  = opB;
      out_d.rd    = in_rd;
      out_d.wr_en = in_wr_en;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register toward execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = out_q.op_a;
  assign out_op_b  = out_q.op_b;
  assign out_rd    = out_q.rd;
  assign out_wr_en = out_q.wr_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model and an
// expected-result queue filled on accept and drained when operands appear.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic [2:0]  in_rd;
  logic        in_wr_en;
  logic [2:0]  rf_rd_addr1;
  logic [2:0]  rf_rd_addr2;
  logic [31:0] rf_rd_data1;
  logic [31:0] rf_rd_data2;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [2:0]  out_rd;
  logic        out_wr_en;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rd;
    logic        wr;
  } exp_t;

  exp_t        expQ[$];
  int          total;
  int          bad;
  logic [31:0] rf[8];
  logic        forceFF;

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_wr_en    (in_wr_en),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op_a    (out_op_a),
    .out_op_b    (out_op_b),
    .out_rd      (out_rd),
    .out_wr_en   (out_wr_en)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file model: reset contents, write on write-back, reg0 fixed at 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'h100 + i;
      rf[0] <= 32'h0;
      rf[3] <= 32'h11;
      rf[4] <= 32'h22;
    end else if (wb_valid && (wb_addr != 3'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign rf_rd_data1 = forceFF ? 32'hFFFF : rf[rf_rd_addr1];
  assign rf_rd_data2 = forceFF ? 32'hFFFF : rf[rf_rd_addr2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                               input logic [2:0] rd, input logic wr);
    in_valid = v;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_wr_en = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rd, input logic wr);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.rd = rd;
    e.wr = wr;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, ".op_a"}, out_op_a, e.a);
      checkOutput({tag, ".op_b"}, out_op_b, e.b);
      checkOutput({tag, ".rd"}, {29'd0, out_rd}, {29'd0, e.rd});
      checkOutput({tag, ".wr_en"}, {31'd0, out_wr_en}, {31'd0, e.wr});
    end
  endtask

  // Directed sequence.
  initial begin
    total     = 0;
    bad       = 0;
    forceFF   = 1'b0;
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = 3'd0;
    wb_data   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.op_a", out_op_a, 32'd0);
    checkOutput("rst.op_b", out_op_b, 32'd0);
    checkOutput("rst.rd", {29'd0, out_rd}, 32'd0);
    checkOutput("rst.wr_en", {31'd0, out_wr_en}, 32'd0);
    checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Plain register-file read.
    applyStimulus(1'b1, 3'd3, 3'd4, 3'd5, 1'b1);
    #1;
    checkOutput("t1.addr1", {29'd0, rf_rd_addr1}, 32'd3);
    checkOutput("t1.addr2", {29'd0, rf_rd_addr2}, 32'd4);
    checkOutput("t1.in_ready", {31'd0, in_ready}, 32'd1);
    pushExp(32'h11, 32'h22, 3'd5, 1'b1);
    tick();
    popCheck("t1");

    // RAW on r5 until its write-back arrives.
    applyStimulus(1'b1, 3'd5, 3'd0, 3'd1, 1'b0);
    #1;
    checkOutput("raw.stall0", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("raw.drained", {31'd0, out_valid}, 32'd0);
    checkOutput("raw.stall1", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1;
    wb_addr  = 3'd5;
    wb_data  = 32'hABCD;
    #1;
`ifdef OPERAND_BYPASS_EN
    checkOutput("raw.wbcycle", {31'd0, in_ready}, 32'd1);
    pushExp(32'hABCD, 32'd0, 3'd1, 1'b0);
    tick();
    wb_valid = 1'b0;
    popCheck("raw.bypass");
`else
    checkOutput("raw.wbcycle", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("raw.after", {31'd0, in_ready}, 32'd1);
    pushExp(32'hABCD, 32'd0, 3'd1, 1'b0);
    tick();
    popCheck("raw.rf");
`endif

    // Back-pressure hold, then back-to-back acceptance.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd4, 3'd3, 3'd7, 1'b1);
    #1;
    checkOutput("bp.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("bp.hold.valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp.hold.op_a", out_op_a, 32'hABCD);
    checkOutput("bp.hold.rd", {29'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp.release", {31'd0, in_ready}, 32'd1);
    pushExp(32'h22, 32'h11, 3'd7, 1'b1);
    tick();
    popCheck("bp.first");
    applyStimulus(1'b1, 3'd3, 3'd0, 3'd2, 1'b1);
    #1;
    checkOutput("bp.b2b", {31'd0, in_ready}, 32'd1);
    pushExp(32'h11, 32'd0, 3'd2, 1'b1);
    tick();
    popCheck("bp.second");

    // reg0 reads zero and never becomes pending.
    forceFF = 1'b1;
    applyStimulus(1'b1, 3'd0, 3'd0, 3'd0, 1'b1);
    #1;
    checkOutput("r0.in_ready", {31'd0, in_ready}, 32'd1);
    pushExp(32'd0, 32'd0, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1);
    popCheck("r0");
    wb_valid = 1'b1;
    wb_addr  = 3'd0;
    wb_data  = 32'h1234;
    tick();
    wb_valid = 1'b0;
    forceFF  = 1'b0;
    #1;
    checkOutput("r0.nopend", {31'd0, in_ready}, 32'd1);

    // Simultaneous clear and set of r2 leaves it pending.
    wb_valid = 1'b1;
    wb_addr  = 3'd2;
    wb_data  = 32'h55;
    applyStimulus(1'b1, 3'd3, 3'd4, 3'd2, 1'b1);
    #1;
    checkOutput("sc.in_ready", {31'd0, in_ready}, 32'd1);
    pushExp(32'h11, 32'h22, 3'd2, 1'b1);
    tick();
    wb_valid = 1'b0;
    popCheck("sc");
    applyStimulus(1'b1, 3'd2, 3'd0, 3'd0, 1'b0);
    #1;
    checkOutput("sc.r2pending", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 3'd0, 3'd0, 3'd7, 1'b1);
    #1;
    checkOutput("waw.r7", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    wb_valid = 1'b1;
    wb_addr  = 3'd2;
    wb_data  = 32'h66;
    tick();
    wb_addr  = 3'd7;
    wb_data  = 32'h77;
    tick();
    wb_valid = 1'b0;
    applyStimulus(1'b0, 3'd2, 3'd7, 3'd7, 1'b1);
    #1;
    checkOutput("wb.cleared", {31'd0, in_ready}, 32'd1);

    // Flush of a held writer to r6.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd3, 3'd4, 3'd6, 1'b1);
    #1;
    checkOutput("fl.load", {31'd0, in_ready}, 32'd1);
    pushExp(32'h11, 32'h22, 3'd6, 1'b1);
    tick();
    popCheck("fl.held");
    applyStimulus(1'b1, 3'd6, 3'd0, 3'd1, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("fl.blocked", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("fl.valid", {31'd0, out_valid}, 32'd0);
    #1;
    checkOutput("fl.r6free", {31'd0, in_ready}, 32'd1);
    pushExp(32'h106, 32'd0, 3'd1, 1'b0);
    tick();
    popCheck("fl.next");
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);

    // Asynchronous reset between clock edges.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst.op_a", out_op_a, 32'd0);
    checkOutput("arst.rd", {29'd0, out_rd}, 32'd0);
    checkOutput("arst.wr_en", {31'd0, out_wr_en}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("arst.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("queue.empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side reader of the 8-entry register file (2 combinational read ports, 1 write port; reg0 reads 0).
- Accepts decoded instructions over a valid/ready handshake and drives the register-file read addresses.
- Bypasses the same-cycle write-back and tracks pending destination writes in a scoreboard, stalling on RAW/WAW hazards.
- Delivers registered operands to the execute stage over a second valid/ready handshake.

Parameters:
WIDTH, 32, data width of operands and write-back data
DEPTH_REG, 8, number of architectural registers
ADDR_W, 3, register address width (log2 DEPTH_REG)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_rs  in  ADDR_W  source register A
in_rt  in  ADDR_W  source register B
in_rd  in  ADDR_W  destination register
in_wr_en  in  1  instruction writes in_rd
rf_rd_addr1  out  ADDR_W  register-file read address 1 (= in_rs, combinational)
rf_rd_addr2  out  ADDR_W  register-file read address 2 (= in_rt, combinational)
rf_rd_data1  in  WIDTH  register-file read data 1
rf_rd_data2  in  WIDTH  register-file read data 2
wb_valid  in  1  write-back this cycle (same as register-file regWrite)
wb_addr  in  ADDR_W  write-back register
wb_data  in  WIDTH  write-back data
flush  in  1  discard held instruction; block acceptance this cycle
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_op_a  out  WIDTH  operand A
out_op_b  out  WIDTH  operand B
out_rd  out  ADDR_W  destination
out_wr_en  out  1  destination write flag

Behaviour:
- Reset: out_valid=0, out_op_a=out_op_b=0, out_rd=0, out_wr_en=0, scoreboard (DEPTH_REG bits) all 0. in_ready is combinational and is 1 after reset when flush=0.
- pending[r] means an accepted instruction will write r and its write-back has not been seen. pending[0] is always 0.
- Source hazard for s in {in_rs, in_rt}: s!=0 and pending[s], excluding the case wb_valid && wb_addr==s (bypass covers it).
- WAW hazard: in_wr_en, in_rd!=0 and pending[in_rd] with no clearing write-back to in_rd this cycle.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept = in_valid && in_ready. On accept, the output register loads on the next posedge (1-cycle latency):
  - op_a: 0 if in_rs==0; else wb_data if wb_valid && wb_addr==in_rs; else rf_rd_data1. op_b is formed the same way.
  - out_rd and out_wr_en are captured; out_valid=1.
- If out_valid && out_ready and there is no accept, out_valid goes to 0. Operand fields hold their values when out_valid=0.
- Scoreboard update, same cycle, priority set > clear:
  - clear pending[wb_addr] when wb_valid;
  - set pending[in_rd] on accept with in_wr_en && in_rd!=0.
  - WAW stall guarantees at most one outstanding writer per register.
- Flush (synchronous, dominates):
  - out_valid goes to 0.
  - If the held instruction had out_wr_en, its pending[out_rd] is cleared, unless the same cycle's write-back already cleared it.
  - No accept in a flush cycle. Pending bits of instructions already past this stage are untouched.
- Write-back to reg0: ignored, no scoreboard change.
- Reset mid-operation returns to the reset state immediately, regardless of clk.

Optional Feature:
OPERAND_BYPASS_EN
- Defined: same-cycle write-back bypass as above.
- Undefined: no bypass. A source hazard also holds when wb_valid && wb_addr==s, which stalls one extra cycle until the register file holds the new value. Operands always come from rf_rd_data or 0.
- WAW rules are unchanged.

Decomposition:
- Shared package def holds: the regAddr typedef; an operand_req_t struct {rs, rt, rd, wr_en}; an operand_out_t struct {op_a, op_b, rd, wr_en}.
- One sub-module, reg_scoreboard: pending bits, set/clear/flush-clear, hazard query for 3 addresses.
- Bypass muxes and the output register stay in operand_fetch.

Test Plan:
- Post-reset read: RF holds r3=0x11, r4=0x22. Issue rs=3, rt=4, rd=5, wr_en=1 with out_ready=1 -> next cycle out_op_a=0x11, out_op_b=0x22, out_rd=5, pending[5]=1.
- RAW stall: with pending[5] set, issue rs=5 -> in_ready=0 until wb_valid, wb_addr=5, wb_data=0xABCD. With OPERAND_BYPASS_EN: accepted in the wb cycle, out_op_a=0xABCD. Without it: accepted one cycle later, operand comes from the RF.
- Back-pressure: out_ready=0 while out_valid=1 -> in_ready=0 and outputs hold. out_ready=1 -> the next instruction is accepted back-to-back, no bubble.
- reg0: issue rs=0, rt=0, rd=0, wr_en=1 with RF data forced to 0xFFFF -> operands 0, no pending bit set. wb_addr=0 -> no change.
- Flush: held instruction has rd=6 and wr_en=1. Assert flush -> out_valid=0, pending[6]=0. An issuing instruction with rs=6 is not accepted that cycle and is accepted the following cycle.
- Simultaneous set and clear: pending[2]=1, wb_addr=2 in the same cycle as accepting rd=2 with wr_en=1 -> pending[2] stays 1.
